// File: rtl/strobe_divider_chain.sv
// strobe_divider_chain
//   Shared timebase built from one base period PERIOD. Stage k runs a
//   free-running counter of period P_k = PERIOD >> k and emits a one-cycle
//   strobe each time it wraps. All stages restart together, so they stay
//   phase-locked. An aligned pulse marks edges where every stage wraps at
//   once, and an epoch counter tallies stage-0 wraps.
//   mismatch flags stages whose halving lost a remainder. cfg_err flags a
//   configuration where the last stage has a zero period. Both are
//   elaboration-time constants.

module strobe_divider_chain #(
  parameter int PERIOD  = 28,
  parameter int STAGES  = 3,
  parameter int EPOCH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               restart,
  output logic [STAGES-1:0]  strobe,
  output logic               aligned,
  output logic [EPOCH_W-1:0] epoch,
  output logic [STAGES-1:0]  mismatch,
  output logic               cfg_err
);

  localparam int CW      = $clog2(PERIOD + 1);
  // A zero-length final stage cannot count. The whole chain is inhibited
  // rather than letting only some stages run.
  localparam bit CFG_ERR = ((PERIOD >> (STAGES - 1)) == 0);

  // Counting happens only on an enabled edge that is not a re-phase.
  logic              advance;
  // Per-stage terminal-count detect, shared by strobe, aligned and epoch.
  logic [STAGES-1:0] wrap;

  assign advance = en && !restart && !CFG_ERR;
  assign cfg_err = CFG_ERR;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int              P_K  = PERIOD >> k;
    // The terminal value is a constant, so the counter can never run past
    // P_K-1. With P_K == 1 it is 0 and the counter simply stays at 0.
    localparam logic [CW-1:0]   LAST = (P_K > 0) ? CW'(P_K - 1) : '0;

    logic [CW-1:0] cnt;
    logic          strobe_q;

    assign wrap[k]     = (cnt == LAST);
    assign strobe[k]   = strobe_q;
    // Halving is exact only if shifting back up recovers PERIOD.
    assign mismatch[k] = (PERIOD != (P_K << k));

    // Stage counter and its wrap strobe; priority is rst, restart, en, hold.
    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (rst) begin
        cnt      <= '0;
        strobe_q <= 1'b0;
      end else if (restart) begin
        cnt      <= '0;
        strobe_q <= 1'b0;
      end else if (advance) begin
        if (wrap[k]) begin
          cnt      <= '0;
          strobe_q <= 1'b1;
        end else begin
          cnt      <= cnt + CW'(1);
          strobe_q <= 1'b0;
        end
      end else begin
        strobe_q <= 1'b0;
      end
    end
  end

  // Coincidence pulse and epoch count, registered alongside the strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      aligned <= 1'b0;
      epoch   <= '0;
    end else if (restart) begin
      // Re-phasing keeps the epoch count; only the pulse is cleared.
      aligned <= 1'b0;
    end else if (advance) begin
      aligned <= &wrap;
      if (wrap[0]) begin
        epoch <= epoch + EPOCH_W'(1);
      end
    end else begin
      aligned <= 1'b0;
    end
  end

endmodule

// File: tb/tb_strobe_divider_chain.sv
// tb_strobe_divider_chain
//   Drives four configurations of strobe_divider_chain from the same inputs:
//   (28,3,8) main, (30,3,8) inexact halving, (4,3,2) unit period with narrow
//   epoch, and (3,3,8) invalid configuration. A reference model counts the
//   enabled edges since the last re-phase and predicts strobes with modulo
//   arithmetic. Hand-derived tables and sequences cover the listed corner
//   cases.

module tb_strobe_divider_chain;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic restart = 1'b0;

  logic [2:0] strb_0, strb_1, strb_2, strb_3;
  logic       al_0, al_1, al_2, al_3;
  logic [7:0] ep_0, ep_1, ep_3;
  logic [1:0] ep_2;
  logic [2:0] mm_0, mm_1, mm_2, mm_3;
  logic       ce_0, ce_1, ce_2, ce_3;

  strobe_divider_chain #(.PERIOD(28), .STAGES(3), .EPOCH_W(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .strobe(strb_0), .aligned(al_0), .epoch(ep_0),
    .mismatch(mm_0), .cfg_err(ce_0));

  strobe_divider_chain #(.PERIOD(30), .STAGES(3), .EPOCH_W(8)) u_p30 (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .strobe(strb_1), .aligned(al_1), .epoch(ep_1),
    .mismatch(mm_1), .cfg_err(ce_1));

  strobe_divider_chain #(.PERIOD(4), .STAGES(3), .EPOCH_W(2)) u_p4 (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .strobe(strb_2), .aligned(al_2), .epoch(ep_2),
    .mismatch(mm_2), .cfg_err(ce_2));

  strobe_divider_chain #(.PERIOD(3), .STAGES(3), .EPOCH_W(8)) u_p3 (
    .clk(clk), .rst(rst), .en(en), .restart(restart),
    .strobe(strb_3), .aligned(al_3), .epoch(ep_3),
    .mismatch(mm_3), .cfg_err(ce_3));

  always #5 clk = ~clk;

  // Gather instance outputs into arrays so the model compare can loop.
  logic [2:0] a_strb [NI];
  logic       a_al   [NI];
  logic [7:0] a_ep   [NI];
  always_comb begin
    a_strb[0] = strb_0; a_strb[1] = strb_1; a_strb[2] = strb_2; a_strb[3] = strb_3;
    a_al[0]   = al_0;   a_al[1]   = al_1;   a_al[2]   = al_2;   a_al[3]   = al_3;
    a_ep[0]   = ep_0;   a_ep[1]   = ep_1;   a_ep[2]   = {6'b0, ep_2}; a_ep[3] = ep_3;
  end

  // Reference model: enabled edges since last re-phase, plus epoch tally.
  int         cfg_period [NI] = '{28, 30, 4, 3};
  int         cfg_ew     [NI] = '{8, 8, 2, 8};
  int         m_n        [NI];
  int         m_ep       [NI];
  logic [2:0] m_s        [NI];
  logic       m_al       [NI];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic rs, input logic e);
    for (int i = 0; i < NI; i++) begin
      if (r) begin
        m_n[i] = 0; m_ep[i] = 0; m_s[i] = '0; m_al[i] = 1'b0;
      end else if (rs) begin
        m_n[i] = 0; m_s[i] = '0; m_al[i] = 1'b0;
      end else if (e) begin
        bit bad;
        bad = ((cfg_period[i] >> 2) == 0);
        m_n[i]++;
        for (int k = 0; k < 3; k++) begin
          int p;
          p = cfg_period[i] >> k;
          m_s[i][k] = !bad && (p > 0) && ((m_n[i] % p) == 0);
        end
        m_al[i] = (m_s[i] == 3'b111);
        if (m_s[i][0]) m_ep[i] = (m_ep[i] + 1) % (1 << cfg_ew[i]);
      end else begin
        m_s[i] = '0; m_al[i] = 1'b0;
      end
    end
  endtask

  // One clock: apply inputs, let the edge happen, update model, compare.
  task automatic step(input logic r, input logic rs, input logic e);
    rst = r; restart = rs; en = e;
    @(posedge clk);
    model_edge(r, rs, e);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("model strobe inst%0d", i), 32'(a_strb[i]), 32'(m_s[i]));
      check($sformatf("model aligned inst%0d", i), 32'(a_al[i]), 32'(m_al[i]));
      check($sformatf("model epoch inst%0d", i), 32'(a_ep[i]), 32'(m_ep[i]));
    end
  endtask

  // Hand-derived vectors for PERIOD=28: advance d enabled edges, then expect.
  typedef struct {
    int         d;
    logic [2:0] exp_strobe;
    logic       exp_aligned;
    logic [7:0] exp_epoch;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int pulses;
    int last_pulse;
    int ep_exp [4];

    vecs[0] = '{7,  3'b100, 1'b0, 8'd0};   // edge 7
    vecs[1] = '{7,  3'b110, 1'b0, 8'd0};   // edge 14
    vecs[2] = '{1,  3'b000, 1'b0, 8'd0};   // edge 15
    vecs[3] = '{6,  3'b100, 1'b0, 8'd0};   // edge 21
    vecs[4] = '{7,  3'b111, 1'b1, 8'd1};   // edge 28
    vecs[5] = '{1,  3'b000, 1'b0, 8'd1};   // edge 29
    vecs[6] = '{27, 3'b111, 1'b1, 8'd2};   // edge 56
    vecs[7] = '{4,  3'b000, 1'b0, 8'd2};   // edge 60

    // Reset state and elaboration constants.
    step(1'b1, 1'b0, 1'b0);
    check("reset strobe", 32'(strb_0), 32'd0);
    check("reset aligned", 32'(al_0), 32'd0);
    check("reset epoch", 32'(ep_0), 32'd0);
    check("mismatch p28", 32'(mm_0), 32'b000);
    check("mismatch p30", 32'(mm_1), 32'b100);
    check("mismatch p4", 32'(mm_2), 32'b000);
    check("mismatch p3", 32'(mm_3), 32'b110);
    check("cfg_err p28", 32'(ce_0), 32'd0);
    check("cfg_err p30", 32'(ce_1), 32'd0);
    check("cfg_err p4", 32'(ce_2), 32'd0);
    check("cfg_err p3", 32'(ce_3), 32'd1);

    // Table-driven run: 60 enabled edges for PERIOD=28.
    for (int v = 0; v < 8; v++) begin
      repeat (vecs[v].d) step(1'b0, 1'b0, 1'b1);
      check($sformatf("vec%0d strobe", v), 32'(strb_0), 32'(vecs[v].exp_strobe));
      check($sformatf("vec%0d aligned", v), 32'(al_0), 32'(vecs[v].exp_aligned));
      check($sformatf("vec%0d epoch", v), 32'(ep_0), 32'(vecs[v].exp_epoch));
    end
    check("p3 inhibited epoch", 32'(ep_3), 32'd0);

    // PERIOD=30: first aligned pulse at enabled edge 210 with epoch 7.
    step(1'b1, 1'b0, 1'b0);
    repeat (209) step(1'b0, 1'b0, 1'b1);
    check("p30 no aligned before 210", 32'(al_1), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    check("p30 aligned at 210", 32'(al_1), 32'd1);
    check("p30 epoch at 210", 32'(ep_1), 32'd7);

    // en toggling: strobe[2] every 14 clocks, one cycle wide.
    step(1'b1, 1'b0, 1'b0);
    pulses = 0;
    last_pulse = -1;
    for (int i = 0; i < 56; i++) begin
      step(1'b0, 1'b0, (i % 2) == 0);
      if (strb_0[2]) begin
        if (last_pulse >= 0) check("toggle interval", 32'(i - last_pulse), 32'd14);
        last_pulse = i;
        pulses++;
      end
    end
    check("toggle pulse count", 32'(pulses), 32'd4);

    // Restart at within-period edge 20 with en=1: partial count discarded.
    step(1'b1, 1'b0, 1'b0);
    repeat (28) step(1'b0, 1'b0, 1'b1);
    repeat (19) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("restart clears strobe", 32'(strb_0), 32'd0);
    check("restart keeps epoch", 32'(ep_0), 32'd1);
    repeat (6) step(1'b0, 1'b0, 1'b1);
    check("post-restart quiet", 32'(strb_0), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    check("post-restart strobe[2]", 32'(strb_0), 32'b100);
    check("post-restart epoch", 32'(ep_0), 32'd1);

    // Simultaneous rst and restart: reset wins, epoch cleared.
    step(1'b1, 1'b1, 1'b1);
    check("rst+restart epoch", 32'(ep_0), 32'd0);

    // PERIOD=4, EPOCH_W=2: epoch 1,2,3,0 at edges 4,8,12,16.
    ep_exp = '{1, 2, 3, 0};
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b0, 1'b1);
      check("p4 strobe[2] every edge", 32'(strb_2[2]), 32'd1);
      if ((i % 4) == 0) check("p4 epoch", 32'(ep_2), 32'(ep_exp[i/4 - 1]));
    end

    // Randomised phase against the model.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 9) < 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
